// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART send queue: FSM state, FIFO entry and length clamp.
package uart_pkg;

   localparam int DEPTH_DEF     = 8;
   localparam int MAX_BYTES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } send_state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  len;
   } entry_t;

   // len is "bytes minus one"; anything past the configured width is cut back to the last legal byte.
   function automatic logic [1:0] clamp_len(input logic [1:0] len, input int max_bytes);
      logic [1:0] w_max;
      w_max = 2'(max_bytes - 1);
      return (len > w_max) ? w_max : len;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, combinational head read, registered count and full flag.
module sync_fifo #(
   parameter  int WIDTH = 34,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [AW:0]      o_count,
   output logic             o_full,
   output logic             o_empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_full;
   logic             w_do_push;
   logic             w_do_pop;
   logic [AW:0]      w_count_next;

   // Full blocks a push even when a pop frees a slot in the same cycle.
   assign w_do_push = i_push && !r_full;
   assign w_do_pop  = i_pop && (r_count != '0);

   always_comb begin
      w_count_next = r_count;
      if (w_do_push && !w_do_pop)
         w_count_next = r_count + 1'b1;
      else if (!w_do_push && w_do_pop)
         w_count_next = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
         r_full  <= (w_count_next == FULL_CNT);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_do_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/uart_send_queue.sv
// Queues 1..4-byte words and feeds them byte by byte, little-endian, to a UART transmitter.
module uart_send_queue
   import uart_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEF,
   parameter int MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_en,
   input  logic [31:0]            req_data,
   input  logic [1:0]             req_len,
   output logic                   req_busy,
   output logic                   tx_en,
   output logic [7:0]             tx_data,
   input  logic                   tx_busy,
   output logic [$clog2(DEPTH):0] count,
   output logic                   idle,
   output send_state_t            dbg_state
);

   // Handshake: a push is taken on a rising edge where req_en=1 and req_busy=0;
   // tx_en is a one-cycle strobe, only raised from an edge where tx_busy was low.

   entry_t                 w_wr_entry;
   entry_t                 w_rd_entry;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [$clog2(DEPTH):0] w_count;
   logic [7:0]             w_byte;

   send_state_t r_state;
   logic [31:0] r_word;
   logic [1:0]  r_len;
   logic [1:0]  r_idx;
   logic        r_tx_en;
   logic [7:0]  r_tx_data;

   assign w_wr_entry = '{data: req_data, len: clamp_len(req_len, MAX_BYTES)};
   assign w_push     = req_en && !w_full;
   assign w_pop      = (r_state == IDLE) && !w_empty;

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_wr_entry),
      .i_pop   (w_pop),
      .o_rdata (w_rd_entry),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_byte = r_word[7:0];
      case (r_idx)
         2'd1:    w_byte = r_word[15:8];
         2'd2:    w_byte = r_word[23:16];
         2'd3:    w_byte = r_word[31:24];
         default: w_byte = r_word[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_word    <= '0;
         r_len     <= '0;
         r_idx     <= '0;
         r_tx_en   <= 1'b0;
         r_tx_data <= '0;
      end else begin
         r_tx_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_word  <= w_rd_entry.data;
                  r_len   <= w_rd_entry.len;
                  r_idx   <= '0;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!tx_busy) begin
                  r_tx_en   <= 1'b1;
                  r_tx_data <= w_byte;
                  r_state   <= HOLD;
               end
            end
            HOLD: begin
               // The HOLD cycle gives the transmitter time to raise tx_busy before the next ISSUE.
               if (r_idx == r_len) begin
                  r_state <= IDLE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= ISSUE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_busy  = w_full;
   assign tx_en     = r_tx_en;
   assign tx_data   = r_tx_data;
   assign count     = w_count;
   assign idle      = w_empty && (r_state == IDLE);
   assign dbg_state = r_state;

endmodule
